// File: rtl/coin_dispenser.sv
// Change/refund dispenser: greedy twenties then tens, one pulse per coin, Moore outputs.
// Define COIN_DISPENSER_INVENTORY_EN to track hopper inventory and flag insufficient change.
module coin_dispenser #(
    parameter int AMT_W       = 6,
    parameter int PULSE_LEN   = 2,
    parameter int GAP_LEN     = 3,
    parameter int TEN_INIT    = 8,
    parameter int TWENTY_INIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] amount_in,
    output logic             req_ready,
    output logic             ten_out,
    output logic             twenty_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {IDLE, CHECK, PULSE, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sel20_q, sel20_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rem_ge2;
    logic twenty_avail;
    logic feasible;
    logic take20;
    logic launch;

    assign rem_ge2 = (32'(rem_q) >= 32'd2);

`ifdef COIN_DISPENSER_INVENTORY_EN
    localparam int CW = ((AMT_W > 8) ? AMT_W : 8) + 1;

    logic [7:0]    inv10_q, inv10_d;
    logic [7:0]    inv20_q, inv20_d;
    logic          err_q, err_d;
    logic [CW-1:0] half_amt, twenties, tens_needed;

    // Greedy plan: as many twenties as the hopper allows, the remainder must fit in tens.
    always_comb begin
        half_amt    = CW'(rem_q >> 1);
        twenties    = (half_amt < CW'(inv20_q)) ? half_amt : CW'(inv20_q);
        tens_needed = CW'(rem_q) - (twenties << 1);
    end

    assign twenty_avail = (inv20_q != 8'd0);
    assign feasible     = (tens_needed <= CW'(inv10_q));
    assign err_out      = (state_q == DONE) && err_q;
`else
    logic unused_init;
    assign unused_init  = ^{TEN_INIT, TWENTY_INIT};
    assign twenty_avail = 1'b1;
    assign feasible     = 1'b1;
    assign err_out      = 1'b0;
`endif

    assign take20 = rem_ge2 && twenty_avail;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel20_d = sel20_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
`ifdef COIN_DISPENSER_INVENTORY_EN
        inv10_d = inv10_q;
        inv20_d = inv20_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rem_d   = amount_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (!feasible) begin
`ifdef COIN_DISPENSER_INVENTORY_EN
                    err_d = 1'b1;
`endif
                    state_d = DONE;
                end else begin
                    launch = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LAST;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    launch = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef COIN_DISPENSER_INVENTORY_EN
                err_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Entering PULSE commits one coin: pick it, take it off rem and the hopper.
        if (launch) begin
            state_d = PULSE;
            cnt_d   = PULSE_LAST;
            sel20_d = take20;
            rem_d   = rem_q - (take20 ? AMT_W'(2) : AMT_W'(1));
`ifdef COIN_DISPENSER_INVENTORY_EN
            if (take20) begin
                inv20_d = (inv20_q != 8'd0) ? inv20_q - 8'd1 : inv20_q;
            end else begin
                inv10_d = (inv10_q != 8'd0) ? inv10_q - 8'd1 : inv10_q;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sel20_q <= 1'b0;
            cnt_q   <= '0;
`ifdef COIN_DISPENSER_INVENTORY_EN
            inv10_q <= 8'(TEN_INIT);
            inv20_q <= 8'(TWENTY_INIT);
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel20_q <= sel20_d;
            cnt_q   <= cnt_d;
`ifdef COIN_DISPENSER_INVENTORY_EN
            inv10_q <= inv10_d;
            inv20_q <= inv20_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign busy_out   = (state_q != IDLE);
    assign done_out   = (state_q == DONE);
    assign twenty_out = (state_q == PULSE) && sel20_q;
    assign ten_out    = (state_q == PULSE) && !sel20_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Self-checking bench for coin_dispenser: per-cycle timeline model plus directed literal checks.
module tb_coin_dispenser;

    localparam int AMT_W = 6;
    localparam int PL    = 2;
    localparam int GL    = 3;
`ifdef COIN_DISPENSER_INVENTORY_EN
    localparam bit INV_EN = 1'b1;
    localparam int T10    = 4;
    localparam int T20    = 1;
`else
    localparam bit INV_EN = 1'b0;
    localparam int T10    = 8;
    localparam int T20    = 8;
`endif

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] amount_in = '0;
    logic             req_ready, ten_out, twenty_out, busy_out, done_out, err_out;

    always #5 clock = ~clock;

    coin_dispenser #(
        .AMT_W(AMT_W), .PULSE_LEN(PL), .GAP_LEN(GL), .TEN_INIT(T10), .TWENTY_INIT(T20)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .amount_in(amount_in),
        .req_ready(req_ready), .ten_out(ten_out), .twenty_out(twenty_out),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
    );

    typedef struct packed {
        logic ten;
        logic twenty;
        logic busy;
        logic done;
        logic err;
        logic start;
    } vec_t;

    vec_t q[$];
    vec_t exp_v    = '0;
    bit   model_ok = 1'b0;
    int   inv10, inv20;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // Expected timeline of one accepted job, one entry per cycle starting with the cycle after the handshake.
    function automatic void plan(input int a);
        int   n20, n10;
        bit   ok;
        vec_t v;
        n20 = a / 2;
        if (INV_EN && n20 > inv20) n20 = inv20;
        n10 = a - 2 * n20;
        ok  = !INV_EN || (n10 <= inv10);
        v = '0; v.busy = 1'b1;
        q.push_back(v);
        if (a != 0 && ok) begin
            for (int c = 0; c < n20 + n10; c++) begin
                for (int p = 0; p < PL; p++) begin
                    v = '0; v.busy = 1'b1; v.start = (p == 0);
                    if (c < n20) v.twenty = 1'b1; else v.ten = 1'b1;
                    q.push_back(v);
                end
                for (int g = 0; g < GL; g++) begin
                    v = '0; v.busy = 1'b1;
                    q.push_back(v);
                end
            end
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1; v.err = !ok;
        q.push_back(v);
    endfunction

    initial forever begin
        @(posedge clock);
        if (reset) begin
            q.delete();
            exp_v    = '0;
            inv10    = T10;
            inv20    = T20;
            model_ok = 1'b1;
        end else begin
            if (model_ok && req_valid && !exp_v.busy) plan(int'(amount_in));
            if (q.size() > 0) begin
                exp_v = q.pop_front();
                if (exp_v.start) begin
                    if (exp_v.twenty) inv20--; else inv10--;
                end
            end else begin
                exp_v = '0;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (model_ok) begin
            chk("ten_out",    ten_out,    exp_v.ten);
            chk("twenty_out", twenty_out, exp_v.twenty);
            chk("busy_out",   busy_out,   exp_v.busy);
            chk("done_out",   done_out,   exp_v.done);
            chk("err_out",    err_out,    exp_v.err);
            chk("req_ready",  req_ready,  int'(!exp_v.busy && !reset));
            chk("one_hot",    ten_out & twenty_out, 0);
        end
    end

    int rec_ten[0:199], rec_tw[0:199], rec_busy[0:199], rec_done[0:199], rec_err[0:199], rec_rdy[0:199];
    int n_ten, n_tw, n_done, n_err;

    task automatic rec(input int k);
        rec_ten[k]  = ten_out;
        rec_tw[k]   = twenty_out;
        rec_busy[k] = busy_out;
        rec_done[k] = done_out;
        rec_err[k]  = err_out;
        rec_rdy[k]  = req_ready;
        if (rec_ten[k] == 1 && rec_ten[k-1] == 0) n_ten++;
        if (rec_tw[k] == 1 && rec_tw[k-1] == 0) n_tw++;
        n_done += rec_done[k];
        n_err  += rec_err[k];
    endtask

    task automatic clr_rec();
        rec_ten[0] = 0; rec_tw[0] = 0;
        n_ten = 0; n_tw = 0; n_done = 0; n_err = 0;
    endtask

    // Handshake in cycle 0, then record cycles 1..n at their falling edges.
    task automatic job(input int a, input int n);
        @(posedge clock); #1;
        req_valid = 1'b1;
        amount_in = AMT_W'(a);
        @(posedge clock); #1;
        req_valid = 1'b0;
        clr_rec();
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            rec(k);
        end
        $display("job amount=%0d twenties=%0d tens=%0d done=%0d err=%0d", a, n_tw, n_ten, n_done, n_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_pulses", ten_out | twenty_out, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", req_ready, 1);

        job(0, 4);
        chk("t2_busy1", rec_busy[1], 1);
        chk("t2_done2", rec_done[2], 1);
        chk("t2_ready3", rec_rdy[3], 1);
        chk("t2_pulses", n_ten + n_tw, 0);
        chk("t2_err", n_err, 0);

`ifdef COIN_DISPENSER_INVENTORY_EN
        job(5, 24);
        chk("t5a_twenties", n_tw, 1);
        chk("t5a_tens", n_ten, 3);
        chk("t5a_done22", rec_done[22], 1);
        chk("t5a_err", n_err, 0);
        job(4, 4);
        chk("t5b_pulses", n_ten + n_tw, 0);
        chk("t5b_done2", rec_done[2], 1);
        chk("t5b_err2", rec_err[2], 1);
        job(1, 8);
        chk("t5c_tens", n_ten, 1);
        chk("t5c_done7", rec_done[7], 1);
        chk("t5c_err", n_err, 0);
        job(1, 4);
        chk("t5d_err2", rec_err[2], 1);
        chk("t5d_pulses", n_ten + n_tw, 0);
`else
        job(3, 14);
        chk("t1_tw2", rec_tw[2], 1);
        chk("t1_tw3", rec_tw[3], 1);
        chk("t1_tw4", rec_tw[4], 0);
        chk("t1_ten7", rec_ten[7], 1);
        chk("t1_ten8", rec_ten[8], 1);
        chk("t1_ten9", rec_ten[9], 0);
        chk("t1_done11", rec_done[11], 0);
        chk("t1_done12", rec_done[12], 1);
        chk("t1_ready12", rec_rdy[12], 0);
        chk("t1_ready13", rec_rdy[13], 1);
        chk("t1_err", n_err, 0);

        // req_valid held high while amount_in keeps changing.
        @(posedge clock); #1;
        req_valid = 1'b1;
        amount_in = AMT_W'(3);
        @(posedge clock);
        clr_rec();
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            rec(k);
            if (k <= 13) amount_in = (k % 2 == 1) ? AMT_W'(1) : AMT_W'(5);
            if (k == 14) req_valid = 1'b0;
        end
        $display("held-valid: twenties=%0d tens=%0d done=%0d", n_tw, n_ten, n_done);
        chk("t3_tw2", rec_tw[2], 1);
        chk("t3_ten7", rec_ten[7], 1);
        chk("t3_done12", rec_done[12], 1);
        chk("t3_ready13", rec_rdy[13], 1);
        chk("t3_busy14", rec_busy[14], 1);
        chk("t3_ten15", rec_ten[15], 1);
        chk("t3_tw15", rec_tw[15], 0);
        chk("t3_done20", rec_done[20], 1);
        chk("t3_done_cnt", n_done, 2);

        // Reset during the second cycle of a twenty pulse.
        @(posedge clock); #1;
        req_valid = 1'b1;
        amount_in = AMT_W'(2);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("t4_tw_cycle3", twenty_out, 1);
        chk("t4_ready_rst", req_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t4_tw_dropped", twenty_out, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t4_ready_back", req_ready, 1);
        clr_rec();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            rec(k);
        end
        $display("after abort: pulses=%0d done=%0d", n_ten + n_tw, n_done);
        chk("t4_no_done", n_done, 0);
        chk("t4_no_pulses", n_ten + n_tw, 0);
        job(1, 8);
        chk("t4_ten2", rec_ten[2], 1);
        chk("t4_ten3", rec_ten[3], 1);
        chk("t4_tens", n_ten, 1);
        chk("t4_twenties", n_tw, 0);
        chk("t4_done7", rec_done[7], 1);

        job(63, 165);
        chk("t6_twenties", n_tw, 31);
        chk("t6_tens", n_ten, 1);
        chk("t6_done161", rec_done[161], 0);
        chk("t6_done162", rec_done[162], 1);
        chk("t6_done_cnt", n_done, 1);
        chk("t6_ready163", rec_rdy[163], 1);
`endif

        repeat (3) @(posedge clock);
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
